// File: rtl/sccb_target.sv
// SCCB/I2C register target: oversamples SCL/SDA on clk, matches a 7-bit device
// address and runs reads/writes through an 8-bit register port with auto-increment.
`timescale 1ns/1ps
module sccb_target #(
   parameter logic [6:0] DEV_ADDR = 7'h18
) (
   input  logic       clk,
   input  logic       res,
   input  logic       scl,
   input  logic       sda_in,
   output logic       sda_oe,
   output logic [7:0] reg_addr,
   output logic [7:0] reg_wdata,
   output logic       reg_wr,
   input  logic [7:0] reg_rdata,
   output logic       busy
);

   typedef enum logic [3:0] {
      ST_IDLE, ST_DEVADDR, ST_DEVACK, ST_REGADDR, ST_REGACK,
      ST_WDATA, ST_WACK, ST_RDATA, ST_MACK, ST_IGNORE
   } state_t;

   // [0] metastability stage, [1] synced value, [2] history
   logic [2:0] scl_pipe_reg, sda_pipe_reg;
   state_t     state_reg, state_next;
   logic [3:0] bit_cnt_reg, bit_cnt_next;
   logic [7:0] shift_reg, shift_next;
   logic       sda_oe_reg, sda_oe_next;
   logic [7:0] reg_addr_reg, reg_addr_next;
   logic [7:0] reg_wdata_reg, reg_wdata_next;
   logic       reg_wr_reg, reg_wr_next;
   logic       busy_reg, busy_next;

   logic scl_sync, scl_hist, sda_sync, sda_hist;
   logic scl_rise, scl_fall, start_det, stop_det, addr_match;

   assign scl_sync   = scl_pipe_reg[1];
   assign scl_hist   = scl_pipe_reg[2];
   assign sda_sync   = sda_pipe_reg[1];
   assign sda_hist   = sda_pipe_reg[2];
   assign scl_rise   = scl_sync & ~scl_hist;
   assign scl_fall   = ~scl_sync & scl_hist;
   assign start_det  = scl_sync & scl_hist & sda_hist & ~sda_sync;
   assign stop_det   = scl_sync & scl_hist & ~sda_hist & sda_sync;
   // general call (7'h00) is never acknowledged
   assign addr_match = (shift_reg[7:1] == DEV_ADDR) && (shift_reg[7:1] != 7'h00);

   always_ff @(posedge clk) begin
      if (res) begin
         scl_pipe_reg  <= 3'b111;
         sda_pipe_reg  <= 3'b111;
         state_reg     <= ST_IDLE;
         bit_cnt_reg   <= 4'd0;
         shift_reg     <= 8'h00;
         sda_oe_reg    <= 1'b0;
         reg_addr_reg  <= 8'h00;
         reg_wdata_reg <= 8'h00;
         reg_wr_reg    <= 1'b0;
         busy_reg      <= 1'b0;
      end else begin
         scl_pipe_reg  <= {scl_pipe_reg[1:0], scl};
         sda_pipe_reg  <= {sda_pipe_reg[1:0], sda_in};
         state_reg     <= state_next;
         bit_cnt_reg   <= bit_cnt_next;
         shift_reg     <= shift_next;
         sda_oe_reg    <= sda_oe_next;
         reg_addr_reg  <= reg_addr_next;
         reg_wdata_reg <= reg_wdata_next;
         reg_wr_reg    <= reg_wr_next;
         busy_reg      <= busy_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      bit_cnt_next   = bit_cnt_reg;
      shift_next     = shift_reg;
      sda_oe_next    = sda_oe_reg;
      reg_addr_next  = reg_addr_reg;
      reg_wdata_next = reg_wdata_reg;
      reg_wr_next    = 1'b0;
      busy_next      = busy_reg;
      if (start_det) begin
         state_next   = ST_DEVADDR;
         bit_cnt_next = 4'd0;
         sda_oe_next  = 1'b0;
      end else if (stop_det) begin
         state_next   = ST_IDLE;
         bit_cnt_next = 4'd0;
         sda_oe_next  = 1'b0;
         busy_next    = 1'b0;
      end else begin
         case (state_reg)
            ST_DEVADDR, ST_REGADDR, ST_WDATA: begin
               if (scl_rise && bit_cnt_reg != 4'd8) begin
                  shift_next   = {shift_reg[6:0], sda_sync};
                  bit_cnt_next = bit_cnt_reg + 4'd1;
                  if (state_reg == ST_WDATA && bit_cnt_reg == 4'd7) begin
                     reg_wdata_next = {shift_reg[6:0], sda_sync};
                     reg_wr_next    = 1'b1;
                  end
               end else if (scl_fall && bit_cnt_reg == 4'd8) begin
                  bit_cnt_next = 4'd0;
                  if (state_reg == ST_DEVADDR) begin
                     if (addr_match) begin
                        state_next  = ST_DEVACK;
                        sda_oe_next = 1'b1;
                        busy_next   = 1'b1;
                     end else begin
                        state_next = ST_IGNORE;
                        busy_next  = 1'b0;
                     end
                  end else begin
                     sda_oe_next = 1'b1;
                     if (state_reg == ST_REGADDR) begin
                        reg_addr_next = shift_reg;
                        state_next    = ST_REGACK;
                     end else begin
                        state_next = ST_WACK;
                     end
                  end
               end
            end
            // one-bit phases: bit_cnt marks that the SCL high half has been seen
            ST_DEVACK, ST_REGACK, ST_WACK, ST_MACK: begin
               if (scl_rise) begin
                  bit_cnt_next = 4'd1;
                  if (state_reg == ST_MACK) begin
                     if (sda_sync) begin
                        state_next = ST_IGNORE;
                        busy_next  = 1'b0;
                     end else begin
                        reg_addr_next = reg_addr_reg + 8'd1;
                     end
                  end
               end else if (scl_fall && bit_cnt_reg == 4'd1) begin
                  if ((state_reg == ST_DEVACK && shift_reg[0]) || state_reg == ST_MACK) begin
                     sda_oe_next  = ~reg_rdata[7];
                     shift_next   = {reg_rdata[6:0], 1'b0};
                     bit_cnt_next = 4'd1;
                     state_next   = ST_RDATA;
                  end else begin
                     sda_oe_next  = 1'b0;
                     bit_cnt_next = 4'd0;
                     if (state_reg == ST_WACK)
                        reg_addr_next = reg_addr_reg + 8'd1;
                     state_next = (state_reg == ST_DEVACK) ? ST_REGADDR : ST_WDATA;
                  end
               end
            end
            ST_RDATA: begin
               if (scl_fall) begin
                  if (bit_cnt_reg == 4'd8) begin
                     sda_oe_next  = 1'b0;
                     bit_cnt_next = 4'd0;
                     state_next   = ST_MACK;
                  end else begin
                     sda_oe_next  = ~shift_reg[7];
                     shift_next   = {shift_reg[6:0], 1'b0};
                     bit_cnt_next = bit_cnt_reg + 4'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign sda_oe    = sda_oe_reg;
   assign reg_addr  = reg_addr_reg;
   assign reg_wdata = reg_wdata_reg;
   assign reg_wr    = reg_wr_reg;
   assign busy      = busy_reg;

endmodule

// File: tb/tb_sccb_target.sv
// Bench for sccb_target: a bit-banged bus master plus a register bank, checked
// against a transaction-level model of the register file and pointer.
`timescale 1ns/1ps
module tb_sccb_target;
   localparam int Q = 5;   // clk cycles per quarter SCL period

   logic       clk = 1'b0;
   logic       res = 1'b1;
   logic       scl_m = 1'b1;
   logic       sda_m = 1'b1;
   logic       sda_line;
   logic       sda_oe, reg_wr, busy;
   logic [7:0] reg_addr, reg_wdata, reg_rdata;

   int n_vec = 0;
   int n_miss = 0;

   always #5 clk = ~clk;

   assign sda_line = sda_m & ~sda_oe;

   sccb_target #(.DEV_ADDR(7'h18)) dut (
      .clk(clk), .res(res), .scl(scl_m), .sda_in(sda_line), .sda_oe(sda_oe),
      .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wr(reg_wr),
      .reg_rdata(reg_rdata), .busy(busy)
   );

   // register bank attached to the DUT port
   logic [7:0]  bank [256];
   logic        bank_init = 1'b0;
   logic [15:0] wr_q [$];
   int          oe_cnt = 0;

   always @(posedge clk) begin
      if (!bank_init) begin
         for (int i = 0; i < 256; i++) bank[i] <= 8'(i) ^ 8'h5A;
         bank_init <= 1'b1;
      end else if (reg_wr) begin
         bank[reg_addr] <= reg_wdata;
         wr_q.push_back({reg_addr, reg_wdata});
      end
      if (sda_oe) oe_cnt <= oe_cnt + 1;
   end

   assign reg_rdata = bank[reg_addr];

   // reference model
   logic [7:0] model_mem [256];
   logic [7:0] ptr;
   logic [7:0] wd [4];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_q();
      repeat (Q) @(negedge clk);
   endtask

   task automatic bus_start();
      sda_m = 1'b1; wait_q();
      scl_m = 1'b1; wait_q();
      sda_m = 1'b0; wait_q();
      scl_m = 1'b0; wait_q();
   endtask

   task automatic bus_stop();
      sda_m = 1'b0; wait_q();
      scl_m = 1'b1; wait_q();
      sda_m = 1'b1; wait_q();
   endtask

   task automatic clock_bit(input logic d, output logic s);
      sda_m = d;    wait_q();
      scl_m = 1'b1; wait_q();
      s = sda_line; wait_q();
      scl_m = 1'b0; wait_q();
   endtask

   task automatic write_byte(input logic [7:0] b, output logic acked);
      logic s;
      for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
      clock_bit(1'b1, s);
      acked = ~s;
   endtask

   task automatic read_byte(input logic nack, output logic [7:0] b);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         clock_bit(1'b1, s);
         b[i] = s;
      end
      clock_bit(nack, s);
   endtask

   task automatic do_write(input logic [7:0] a, input int n);
      logic       ack;
      logic [7:0] ai;
      wr_q.delete();
      bus_start();
      write_byte(8'h30, ack);  check("wr_devack", 32'(ack), 1);
      check("wr_busy_mid", 32'(busy), 1);
      write_byte(a, ack);      check("wr_regack", 32'(ack), 1);
      for (int i = 0; i < n; i++) begin
         write_byte(wd[i], ack); check("wr_dataack", 32'(ack), 1);
      end
      bus_stop();
      repeat (4) @(negedge clk);
      check("wr_count", 32'(wr_q.size()), 32'(n));
      for (int i = 0; i < n; i++) begin
         ai = a + 8'(i);
         model_mem[ai] = wd[i];
         if (i < wr_q.size()) check("wr_strobe", 32'(wr_q[i]), 32'({ai, wd[i]}));
      end
      ptr = a + 8'(n);
      check("wr_ptr", 32'(reg_addr), 32'(ptr));
      check("wr_busy_end", 32'(busy), 0);
      $display("write  addr=%02h bytes=%0d", a, n);
   endtask

   task automatic do_read(input logic set_ptr, input logic [7:0] a, input int k);
      logic       ack;
      logic [7:0] b;
      wr_q.delete();
      if (set_ptr) begin
         bus_start();
         write_byte(8'h30, ack); check("rd_wdevack", 32'(ack), 1);
         write_byte(a, ack);     check("rd_regack", 32'(ack), 1);
         ptr = a;
      end
      bus_start();
      write_byte(8'h31, ack);    check("rd_devack", 32'(ack), 1);
      for (int i = 0; i < k; i++) begin
         read_byte(i == k - 1, b);
         check("rd_data", 32'(b), 32'(model_mem[ptr + 8'(i)]));
      end
      check("rd_release", 32'(sda_oe), 0);
      check("rd_busy_nack", 32'(busy), 0);
      bus_stop();
      repeat (4) @(negedge clk);
      ptr = ptr + 8'(k - 1);
      check("rd_ptr", 32'(reg_addr), 32'(ptr));
      check("rd_nowrite", 32'(wr_q.size()), 0);
      $display("read   set=%0d addr=%02h bytes=%0d", set_ptr, ptr, k);
   endtask

   task automatic do_nomatch(input logic [6:0] dev);
      logic ack;
      int   oe0;
      wr_q.delete();
      oe0 = oe_cnt;
      bus_start();
      write_byte({dev, 1'b0}, ack); check("nm_devack", 32'(ack), 0);
      write_byte(8'h05, ack);       check("nm_byteack", 32'(ack), 0);
      bus_stop();
      repeat (4) @(negedge clk);
      check("nm_nowrite", 32'(wr_q.size()), 0);
      check("nm_oe", 32'(oe_cnt - oe0), 0);
      check("nm_ptr", 32'(reg_addr), 32'(ptr));
      check("nm_busy", 32'(busy), 0);
      $display("nomatch dev=%02h", dev);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic       ack, s;
      logic [7:0] rb;
      int         r, n;
      logic [6:0] dev;

      for (int i = 0; i < 256; i++) model_mem[i] = 8'(i) ^ 8'h5A;
      ptr = 8'h00;

      repeat (4) @(negedge clk);
      check("rst_sda_oe", 32'(sda_oe), 0);
      check("rst_reg_wr", 32'(reg_wr), 0);
      check("rst_addr", 32'(reg_addr), 0);
      check("rst_wdata", 32'(reg_wdata), 0);
      check("rst_busy", 32'(busy), 0);
      res = 1'b0;
      repeat (8) @(negedge clk);
      $display("reset  done");

      wd[0] = 8'hA7;
      do_write(8'h05, 1);
      wd[0] = 8'h11; wd[1] = 8'h22; wd[2] = 8'h33;
      do_write(8'hFE, 3);
      do_read(1'b1, 8'h10, 2);
      do_nomatch(7'h21);
      do_nomatch(7'h00);
      wd[0] = 8'h5C;
      do_write(8'h40, 1);

      // STOP in the middle of the 4th data bit
      wr_q.delete();
      bus_start();
      write_byte(8'h30, ack); check("ab_devack", 32'(ack), 1);
      write_byte(8'h20, ack); check("ab_regack", 32'(ack), 1);
      ptr = 8'h20;
      for (int i = 0; i < 3; i++) clock_bit(1'($urandom_range(0, 1)), s);
      sda_m = 1'b0; wait_q();
      scl_m = 1'b1; wait_q();
      sda_m = 1'b1; wait_q();
      repeat (4) @(negedge clk);
      check("ab_nowrite", 32'(wr_q.size()), 0);
      check("ab_busy", 32'(busy), 0);
      check("ab_ptr", 32'(reg_addr), 32'(ptr));
      check("ab_oe", 32'(sda_oe), 0);
      $display("abort  stop in bit 4");

      // reset pulse while the target holds ACK
      bus_start();
      write_byte(8'h30, ack); check("rs_devack", 32'(ack), 1);
      for (int i = 7; i >= 0; i--) clock_bit(rb[i] ^ 1'b0 ? 1'b0 : 1'b0, s);
      sda_m = 1'b1; wait_q();
      check("rs_ack_held", 32'(sda_oe), 1);
      res = 1'b1;
      @(negedge clk);
      check("rs_released", 32'(sda_oe), 0);
      check("rs_busy", 32'(busy), 0);
      check("rs_ptr", 32'(reg_addr), 0);
      res = 1'b0;
      ptr = 8'h00;
      scl_m = 1'b1; wait_q(); wait_q();
      scl_m = 1'b0; wait_q();
      write_byte(8'h30, ack); check("rs_nostart", 32'(ack), 0);
      bus_stop();
      repeat (4) @(negedge clk);
      $display("reset  during ack");

      for (int t = 0; t < 24; t++) begin
         r = $urandom_range(0, 9);
         if (r < 5) begin
            n = $urandom_range(1, 3);
            for (int i = 0; i < n; i++) wd[i] = 8'($urandom);
            do_write(8'($urandom), n);
         end else if (r < 9) begin
            do_read(1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(1, 3));
         end else begin
            dev = 7'($urandom_range(0, 127));
            if (dev == 7'h18) dev = 7'h19;
            do_nomatch(dev);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
